bp_me_mem_arbiter: RTL and testbench

Shares one memory command/response port (bp_mem or a DRAM controller) among `num_req_p` requesters, such as multiple CCEs, or a CCE plus the config loader.
- Commands are granted round-robin.
- The requester ID of each issued command is recorded in an order FIFO.
- Memory responses, which arrive in command order, are routed back to the requester at the FIFO head.
- An outstanding-command credit limit bounds buffering and prevents the deadlock caused by issuing more commands than the memory-side response buffers can absorb.

---
 rtl/bp_me_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_bp_me_mem_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_mem_arbiter.sv
// Shares one memory command/response port among num_req_p requesters.
// Commands are granted round-robin and gated by an outstanding-command
// credit. The requester ID of each issued command goes into an order FIFO,
// so in-order memory responses can be routed back to the right requester.
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   cmd_i/cmd_v_i/cmd_ready_o  per-requester command ready-valid
//   mem_cmd_o/_v_o/_ready_i  command to memory (ready-valid)
//   mem_resp_i/_v_i/_yumi_o  response from memory (valid-yumi)
//   resp_o/resp_v_o/resp_yumi_i  shared response data, one-hot valid
//   outstanding_o            commands issued but not yet answered
//   error_o                  sticky: response arrived with none outstanding

module bp_me_mem_arbiter #(
   parameter  int num_req_p         = 2,
   parameter  int msg_width_p       = 64,
   parameter  int max_outstanding_p = 4,
   localparam int cnt_width_lp      = $clog2(max_outstanding_p + 1)
) (
   input  logic                             clk_i,
   input  logic                             reset_i,

   input  logic [num_req_p*msg_width_p-1:0] cmd_i,
   input  logic [num_req_p-1:0]             cmd_v_i,
   output logic [num_req_p-1:0]             cmd_ready_o,

   output logic [msg_width_p-1:0]           mem_cmd_o,
   output logic                             mem_cmd_v_o,
   input  logic                             mem_cmd_ready_i,

   input  logic [msg_width_p-1:0]           mem_resp_i,
   input  logic                             mem_resp_v_i,
   output logic                             mem_resp_yumi_o,

   output logic [msg_width_p-1:0]           resp_o,
   output logic [num_req_p-1:0]             resp_v_o,
   input  logic [num_req_p-1:0]             resp_yumi_i,

   output logic [cnt_width_lp-1:0]          outstanding_o,
   output logic                             error_o
);

   localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int sum_width_lp = id_width_lp + 1;
   localparam int ptr_width_lp =
      (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

   typedef logic [id_width_lp-1:0]  id_t;
   typedef logic [ptr_width_lp-1:0] ptr_t;
   typedef logic [cnt_width_lp-1:0] cnt_t;

   id_t  rr_q;
   cnt_t count_q;
   logic error_q;
   ptr_t wptr_q;
   ptr_t rptr_q;
   id_t  fifo_mem [max_outstanding_p];

   logic                    credit_avail;
   logic                    cmd_hs;
   logic                    found;
   logic [sum_width_lp-1:0] idx;
   id_t                     grant_id;
   logic [num_req_p-1:0]    grant;
   logic                    fifo_v;
   id_t                     head_id;

   // Credit is evaluated on registered state only, so a credit freed by a
   // response this cycle is not reusable until the next cycle.
   assign credit_avail = (count_q < cnt_t'(max_outstanding_p));

   // Scan from the priority pointer, wrapping, for the first valid requester.
   always_comb begin
      found    = 1'b0;
      grant_id = '0;
      idx      = '0;
      for (int i = 0; i < num_req_p; i++) begin
         idx = {1'b0, rr_q} + sum_width_lp'(i);
         if (idx >= sum_width_lp'(num_req_p))
            idx = idx - sum_width_lp'(num_req_p);
         if (!found && cmd_v_i[idx[id_width_lp-1:0]]) begin
            found    = 1'b1;
            grant_id = idx[id_width_lp-1:0];
         end
      end
   end

   always_comb begin
      grant           = '0;
      grant[grant_id] = found;
   end

   assign mem_cmd_v_o = (|cmd_v_i) & credit_avail;
   assign mem_cmd_o   = cmd_i[grant_id*msg_width_p +: msg_width_p];
   assign cmd_ready_o =
      grant & {num_req_p{mem_cmd_ready_i & credit_avail}};
   assign cmd_hs      = mem_cmd_v_o & mem_cmd_ready_i;

   // Occupancy of the order FIFO equals the outstanding count.
   assign fifo_v  = (count_q != '0);
   assign head_id = fifo_mem[rptr_q];

   assign resp_o = mem_resp_i;

   always_comb begin
      resp_v_o          = '0;
      resp_v_o[head_id] = mem_resp_v_i & fifo_v;
   end

   assign mem_resp_yumi_o =
      mem_resp_v_i & fifo_v & resp_yumi_i[head_id];

   assign outstanding_o = count_q;
   assign error_o       = error_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rr_q    <= '0;
         count_q <= '0;
         error_q <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
      end else begin
         if (cmd_hs) begin
            rr_q <= (grant_id == id_t'(num_req_p - 1))
                  ? '0 : grant_id + id_t'(1);
            wptr_q <= (wptr_q == ptr_t'(max_outstanding_p - 1))
                    ? '0 : wptr_q + ptr_t'(1);
         end
         if (mem_resp_yumi_o)
            rptr_q <= (rptr_q == ptr_t'(max_outstanding_p - 1))
                    ? '0 : rptr_q + ptr_t'(1);
         if (cmd_hs && !mem_resp_yumi_o)
            count_q <= count_q + cnt_t'(1);
         else if (!cmd_hs && mem_resp_yumi_o)
            count_q <= count_q - cnt_t'(1);
         if (mem_resp_v_i && !fifo_v)
            error_q <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk_i) begin
      if (cmd_hs)
         fifo_mem[wptr_q] <= grant_id;
   end

endmodule

// File: tb/tb_bp_me_mem_arbiter.sv
// Directed self-checking bench for bp_me_mem_arbiter (2 requesters,
// 64-bit messages, 4 credits). Inputs change on negedge, checks at +1.

module tb_bp_me_mem_arbiter;

   localparam int N = 2;
   localparam int W = 64;
   localparam int M = 4;

   logic           clk_i = 1'b0;
   logic           reset_i;
   logic [N*W-1:0] cmd_i;
   logic [N-1:0]   cmd_v_i;
   logic [N-1:0]   cmd_ready_o;
   logic [W-1:0]   mem_cmd_o;
   logic           mem_cmd_v_o;
   logic           mem_cmd_ready_i;
   logic [W-1:0]   mem_resp_i;
   logic           mem_resp_v_i;
   logic           mem_resp_yumi_o;
   logic [W-1:0]   resp_o;
   logic [N-1:0]   resp_v_o;
   logic [N-1:0]   resp_yumi_i;
   logic [2:0]     outstanding_o;
   logic           error_o;

   int checks = 0;
   int errors = 0;

   bp_me_mem_arbiter #(
      .num_req_p(N), .msg_width_p(W), .max_outstanding_p(M)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
      .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o),
      .mem_cmd_ready_i(mem_cmd_ready_i),
      .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i),
      .mem_resp_yumi_o(mem_resp_yumi_o),
      .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
      .outstanding_o(outstanding_o), .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic next_cycle();
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      cmd_v_i = '0;
      mem_resp_v_i = 1'b0;
      resp_yumi_i = '0;
      next_cycle();
      reset_i = 1'b0;
   endtask

   task automatic test_reset();
      mem_cmd_ready_i = 1'b1;
      cmd_i = {64'hB1, 64'hA0};
      mem_resp_i = '0;
      do_reset();
      next_cycle();
      do_reset();
      #1;
      checks++;
      if (outstanding_o !== 3'd0) begin
         errors++;
         $display("FAIL rst_count got %0d exp 0", outstanding_o);
      end
      checks++;
      if (error_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_error got %b exp 0", error_o);
      end
      checks++;
      if (resp_v_o !== 2'b00 || mem_resp_yumi_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_resp got %b/%b exp 00/0",
                  resp_v_o, mem_resp_yumi_o);
      end
      cmd_v_i = 2'b11;
      #1;
      checks++;
      if (cmd_ready_o !== 2'b01 || mem_cmd_o !== 64'hA0) begin
         errors++;
         $display("FAIL rst_first_grant got %b/%h exp 01/a0",
                  cmd_ready_o, mem_cmd_o);
      end
      cmd_v_i = 2'b00;
   endtask

   task automatic test_single();
      do_reset();
      mem_cmd_ready_i = 1'b1;
      cmd_v_i = 2'b01;
      for (int k = 0; k < 4; k++) begin
         cmd_i = {64'hB1, 64'(100 + k)};
         #1;
         checks++;
         if (cmd_ready_o !== 2'b01 || mem_cmd_v_o !== 1'b1 ||
             mem_cmd_o !== 64'(100 + k) || outstanding_o !== 3'(k)) begin
            errors++;
            $display("FAIL single_issue%0d got %b/%b/%h/%0d exp 01/1/%h/%0d",
                     k, cmd_ready_o, mem_cmd_v_o, mem_cmd_o,
                     outstanding_o, 64'(100 + k), k);
         end
         next_cycle();
      end
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (outstanding_o !== 3'd4 || cmd_ready_o !== 2'b00 ||
             mem_cmd_v_o !== 1'b0) begin
            errors++;
            $display("FAIL single_full got %0d/%b/%b exp 4/00/0",
                     outstanding_o, cmd_ready_o, mem_cmd_v_o);
         end
         next_cycle();
      end
      mem_resp_v_i = 1'b1;
      resp_yumi_i = 2'b01;
      #1;
      checks++;
      if (resp_v_o !== 2'b01 || mem_resp_yumi_o !== 1'b1 ||
          cmd_ready_o !== 2'b00) begin
         errors++;
         $display("FAIL single_free got %b/%b/%b exp 01/1/00",
                  resp_v_o, mem_resp_yumi_o, cmd_ready_o);
      end
      next_cycle();
      mem_resp_v_i = 1'b0;
      #1;
      checks++;
      if (outstanding_o !== 3'd3 || cmd_ready_o !== 2'b01) begin
         errors++;
         $display("FAIL single_credit got %0d/%b exp 3/01",
                  outstanding_o, cmd_ready_o);
      end
      cmd_v_i = 2'b00;
      mem_resp_v_i = 1'b1;
      for (int k = 0; k < 3; k++) next_cycle();
      mem_resp_v_i = 1'b0;
      resp_yumi_i = 2'b00;
      #1;
      checks++;
      if (outstanding_o !== 3'd0) begin
         errors++;
         $display("FAIL single_drain got %0d exp 0", outstanding_o);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      cmd_i = {64'hB1, 64'hA0};
      mem_cmd_ready_i = 1'b1;
      cmd_v_i = 2'b11;
      resp_yumi_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         mem_resp_v_i = (i > 0);
         #1;
         checks++;
         if (cmd_ready_o !== ((i % 2) ? 2'b10 : 2'b01) ||
             mem_cmd_o !== ((i % 2) ? 64'hB1 : 64'hA0)) begin
            errors++;
            $display("FAIL fair_grant%0d got %b/%h exp %b", i,
                     cmd_ready_o, mem_cmd_o,
                     (i % 2) ? 2'b10 : 2'b01);
         end
         if (i > 0) begin
            checks++;
            if (resp_v_o !== (((i - 1) % 2) ? 2'b10 : 2'b01) ||
                mem_resp_yumi_o !== 1'b1) begin
               errors++;
               $display("FAIL fair_resp%0d got %b/%b exp %b/1", i,
                        resp_v_o, mem_resp_yumi_o,
                        ((i - 1) % 2) ? 2'b10 : 2'b01);
            end
         end
         next_cycle();
      end
      cmd_v_i = 2'b00;
      mem_resp_v_i = 1'b1;
      #1;
      checks++;
      if (resp_v_o !== 2'b10 || outstanding_o !== 3'd1) begin
         errors++;
         $display("FAIL fair_last got %b/%0d exp 10/1",
                  resp_v_o, outstanding_o);
      end
      next_cycle();
      mem_resp_v_i = 1'b0;
      resp_yumi_i = 2'b00;
   endtask

   task automatic test_ordering();
      logic [N-1:0] seq [3];
      logic [W-1:0] dat [3];
      seq[0] = 2'b10; seq[1] = 2'b01; seq[2] = 2'b10;
      dat[0] = 64'hAAAA; dat[1] = 64'hBBBB; dat[2] = 64'hCCCC;
      do_reset();
      mem_cmd_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cmd_v_i = seq[k];
         #1;
         checks++;
         if (cmd_ready_o !== seq[k]) begin
            errors++;
            $display("FAIL order_issue%0d got %b exp %b",
                     k, cmd_ready_o, seq[k]);
         end
         next_cycle();
      end
      cmd_v_i = 2'b00;
      mem_resp_v_i = 1'b1;
      mem_resp_i = dat[0];
      resp_yumi_i = 2'b01;
      #1;
      checks++;
      if (resp_v_o !== 2'b10 || mem_resp_yumi_o !== 1'b0 ||
          resp_o !== 64'hAAAA) begin
         errors++;
         $display("FAIL order_wait got %b/%b/%h exp 10/0/aaaa",
                  resp_v_o, mem_resp_yumi_o, resp_o);
      end
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         mem_resp_i = dat[k];
         resp_yumi_i = seq[k];
         #1;
         checks++;
         if (resp_v_o !== seq[k] || mem_resp_yumi_o !== 1'b1 ||
             resp_o !== dat[k]) begin
            errors++;
            $display("FAIL order_resp%0d got %b/%b/%h exp %b/1/%h",
                     k, resp_v_o, mem_resp_yumi_o, resp_o,
                     seq[k], dat[k]);
         end
         next_cycle();
      end
      mem_resp_v_i = 1'b0;
      resp_yumi_i = 2'b00;
      #1;
      checks++;
      if (outstanding_o !== 3'd0) begin
         errors++;
         $display("FAIL order_drain got %0d exp 0", outstanding_o);
      end
   endtask

   task automatic test_stall();
      do_reset();
      cmd_i = {64'hB1, 64'hA0};
      mem_cmd_ready_i = 1'b1;
      cmd_v_i = 2'b01;
      next_cycle();
      cmd_v_i = 2'b11;
      mem_cmd_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== 64'hB1 ||
             cmd_ready_o !== 2'b00 || outstanding_o !== 3'd1) begin
            errors++;
            $display("FAIL stall%0d got %b/%h/%b/%0d exp 1/b1/00/1",
                     k, mem_cmd_v_o, mem_cmd_o, cmd_ready_o,
                     outstanding_o);
         end
         next_cycle();
      end
      mem_cmd_ready_i = 1'b1;
      #1;
      checks++;
      if (cmd_ready_o !== 2'b10 || mem_cmd_o !== 64'hB1) begin
         errors++;
         $display("FAIL stall_release got %b/%h exp 10/b1",
                  cmd_ready_o, mem_cmd_o);
      end
      cmd_v_i = 2'b11;
      next_cycle();
      cmd_v_i = 2'b00;
      #1;
      checks++;
      if (outstanding_o !== 3'd2) begin
         errors++;
         $display("FAIL stall_count got %0d exp 2", outstanding_o);
      end
   endtask

   // Continues from test_stall: 2 outstanding, FIFO holds ids 0 then 1.
   task automatic test_simultaneous();
      cmd_v_i = 2'b01;
      mem_resp_v_i = 1'b1;
      resp_yumi_i = 2'b01;
      #1;
      checks++;
      if (cmd_ready_o !== 2'b01 || resp_v_o !== 2'b01 ||
          mem_resp_yumi_o !== 1'b1) begin
         errors++;
         $display("FAIL simul_both got %b/%b/%b exp 01/01/1",
                  cmd_ready_o, resp_v_o, mem_resp_yumi_o);
      end
      next_cycle();
      cmd_v_i = 2'b00;
      resp_yumi_i = 2'b11;
      #1;
      checks++;
      if (outstanding_o !== 3'd2 || resp_v_o !== 2'b10) begin
         errors++;
         $display("FAIL simul_count got %0d/%b exp 2/10",
                  outstanding_o, resp_v_o);
      end
      next_cycle();
      #1;
      checks++;
      if (outstanding_o !== 3'd1 || resp_v_o !== 2'b01) begin
         errors++;
         $display("FAIL simul_order got %0d/%b exp 1/01",
                  outstanding_o, resp_v_o);
      end
      next_cycle();
      mem_resp_v_i = 1'b0;
      resp_yumi_i = 2'b00;
   endtask

   task automatic test_error();
      mem_resp_v_i = 1'b1;
      resp_yumi_i = 2'b11;
      #1;
      checks++;
      if (mem_resp_yumi_o !== 1'b0 || resp_v_o !== 2'b00 ||
          error_o !== 1'b0 || outstanding_o !== 3'd0) begin
         errors++;
         $display("FAIL err_comb got %b/%b/%b/%0d exp 0/00/0/0",
                  mem_resp_yumi_o, resp_v_o, error_o, outstanding_o);
      end
      next_cycle();
      mem_resp_v_i = 1'b0;
      resp_yumi_i = 2'b00;
      #1;
      checks++;
      if (error_o !== 1'b1) begin
         errors++;
         $display("FAIL err_set got %b exp 1", error_o);
      end
      next_cycle();
      #1;
      checks++;
      if (error_o !== 1'b1 || outstanding_o !== 3'd0) begin
         errors++;
         $display("FAIL err_sticky got %b/%0d exp 1/0",
                  error_o, outstanding_o);
      end
   endtask

   task automatic test_reset_mid();
      mem_cmd_ready_i = 1'b1;
      cmd_v_i = 2'b01;
      for (int k = 0; k < 3; k++) next_cycle();
      cmd_v_i = 2'b00;
      #1;
      checks++;
      if (outstanding_o !== 3'd3) begin
         errors++;
         $display("FAIL mid_pre got %0d exp 3", outstanding_o);
      end
      do_reset();
      #1;
      checks++;
      if (outstanding_o !== 3'd0 || error_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_clear got %0d/%b exp 0/0",
                  outstanding_o, error_o);
      end
      cmd_v_i = 2'b11;
      mem_resp_v_i = 1'b1;
      resp_yumi_i = 2'b11;
      #1;
      checks++;
      if (cmd_ready_o !== 2'b01 || resp_v_o !== 2'b00 ||
          mem_resp_yumi_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_rr got %b/%b/%b exp 01/00/0",
                  cmd_ready_o, resp_v_o, mem_resp_yumi_o);
      end
      cmd_v_i = 2'b00;
      mem_resp_v_i = 1'b0;
      resp_yumi_i = 2'b00;
   endtask

   initial begin
      reset_i = 1'b1;
      cmd_i = '0;
      cmd_v_i = '0;
      mem_cmd_ready_i = 1'b0;
      mem_resp_i = '0;
      mem_resp_v_i = 1'b0;
      resp_yumi_i = '0;
      next_cycle();
      test_reset();
      test_single();
      test_fairness();
      test_ordering();
      test_stall();
      test_simultaneous();
      test_error();
      test_reset_mid();
      next_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
